// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: main sequencing FSM plus the ALU decoder.
// Instructions are walked through fetch, decode, execute, memory and
// writeback over several cycles. EXECUTE is stretched for mul until the
// multiplier has had MUL_LATENCY cycles. Undefined opcode/funct values
// either enter a sticky TRAP or are dropped as a nop (TRAP_ON_ILLEGAL).
//
// Ports
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   opcode       : instr[31:26] from the instruction register
//   funct        : instr[5:0] from the instruction register
//   zero         : ALU zero flag (only used for the beq PC write)
//   pc_en        : PC write enable
//   iord         : memory address select (0 = PC, 1 = ALUOut)
//   mem_write    : data memory write
//   ir_write     : instruction register load
//   reg_dst      : write register select (0 = rt, 1 = rd)
//   mem_to_reg   : writeback select (0 = ALUOut, 1 = memory data)
//   reg_write    : register file write
//   alu_src_a    : ALU A select (0 = PC, 1 = A)
//   alu_src_b    : ALU B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   alu_control  : 000 and, 001 or, 010 add, 100 sub, 101 mul, 110 slt
//   pc_src       : PC source (00 ALUResult, 01 ALUOut, 10 jump target)
//   state        : current state code, for debug
//   illegal      : sticky trap flag
module mips_multicycle_ctrl #(
    parameter int unsigned MUL_LATENCY     = 3,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       illegal
);

    // Four bits hold MUL_LATENCY-2 for the whole legal range 1..15.
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MUL_LOAD =
        (MUL_LATENCY > 1) ? CNT_W'(MUL_LATENCY - 2) : '0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_MUL = 6'b011100;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic [3:0] {
        S_BOOT    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_MULWAIT = 4'd8,
        S_ALUWB   = 4'd9,
        S_BRANCH  = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12,
        S_JUMP    = 4'd13,
        S_TRAP    = 4'd14
    } state_t;

    // Where an undefined opcode/funct sends the FSM.
    localparam state_t ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

    state_t           state_q;
    logic [CNT_W-1:0] mul_cnt;
    logic             illegal_q;
    logic             is_sw_q;
    logic [2:0]       funct_alu;
    logic             funct_ok;

    // ALU decoder for R-type funct; unknown funct falls back to add.
    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (funct)
            F_ADD:   funct_alu = ALU_ADD;
            F_SUB:   funct_alu = ALU_SUB;
            F_AND:   funct_alu = ALU_AND;
            F_OR:    funct_alu = ALU_OR;
            F_SLT:   funct_alu = ALU_SLT;
            F_MUL:   funct_alu = ALU_MUL;
            default: funct_ok  = 1'b0;
        endcase
    end

    // State sequencing, mul wait counter and sticky trap flag.
    // lw/sw is latched in DECODE so opcode is not looked at again in MEMADR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_BOOT;
            mul_cnt   <= '0;
            illegal_q <= 1'b0;
            is_sw_q   <= 1'b0;
        end else begin
            case (state_q)
                S_BOOT:   state_q <= S_FETCH;
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    is_sw_q <= (opcode == OP_SW);
                    case (opcode)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default: begin
                            state_q   <= ILLEGAL_NEXT;
                            illegal_q <= TRAP_ON_ILLEGAL;
                        end
                    endcase
                end
                S_MEMADR: state_q <= is_sw_q ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_q <= S_MEMWB;
                S_MEMWB:  state_q <= S_FETCH;
                S_MEMWR:  state_q <= S_FETCH;
                S_EXECUTE: begin
                    if (!funct_ok) begin
                        state_q   <= ILLEGAL_NEXT;
                        illegal_q <= TRAP_ON_ILLEGAL;
                    end else if ((funct == F_MUL) && (MUL_LATENCY > 1)) begin
                        // EXECUTE counts as the first mul cycle.
                        mul_cnt <= MUL_LOAD;
                        state_q <= S_MULWAIT;
                    end else begin
                        state_q <= S_ALUWB;
                    end
                end
                S_MULWAIT: begin
                    if (mul_cnt == '0) begin
                        state_q <= S_ALUWB;
                    end else begin
                        mul_cnt <= mul_cnt - CNT_W'(1);
                    end
                end
                S_ALUWB:  state_q <= S_FETCH;
                S_BRANCH: state_q <= S_FETCH;
                S_ADDIEX: state_q <= S_ADDIWB;
                S_ADDIWB: state_q <= S_FETCH;
                S_JUMP:   state_q <= S_FETCH;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Moore output decode from the state register; pc_en in BRANCH follows zero.
    always_comb begin
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        pc_src      = 2'b00;
        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_en     = 1'b1;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            S_MULWAIT: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_MUL;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en       = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. Two instances share the inputs:
// dut_a (MUL_LATENCY=3, trapping) and dut_b (MUL_LATENCY=1, nop on illegal).
// Outputs are packed as {state, pc_en, iord, mem_write, ir_write, reg_dst,
// mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, pc_src, illegal}.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       a_pc_en, a_iord, a_mem_write, a_ir_write, a_reg_dst;
    logic       a_mem_to_reg, a_reg_write, a_alu_src_a, a_illegal;
    logic [1:0] a_alu_src_b, a_pc_src;
    logic [2:0] a_alu_control;
    logic [3:0] a_state;

    logic       b_pc_en, b_iord, b_mem_write, b_ir_write, b_reg_dst;
    logic       b_mem_to_reg, b_reg_write, b_alu_src_a, b_illegal;
    logic [1:0] b_alu_src_b, b_pc_src;
    logic [2:0] b_alu_control;
    logic [3:0] b_state;

    logic [19:0] va, vb;
    int pass_cnt  = 0;
    int total_cnt = 0;

    mips_multicycle_ctrl #(.MUL_LATENCY(3), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(a_pc_en), .iord(a_iord), .mem_write(a_mem_write),
        .ir_write(a_ir_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
        .reg_write(a_reg_write), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .alu_control(a_alu_control), .pc_src(a_pc_src), .state(a_state),
        .illegal(a_illegal)
    );

    mips_multicycle_ctrl #(.MUL_LATENCY(1), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(b_pc_en), .iord(b_iord), .mem_write(b_mem_write),
        .ir_write(b_ir_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
        .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_control(b_alu_control), .pc_src(b_pc_src), .state(b_state),
        .illegal(b_illegal)
    );

    assign va = {a_state, a_pc_en, a_iord, a_mem_write, a_ir_write, a_reg_dst,
                 a_mem_to_reg, a_reg_write, a_alu_src_a, a_alu_src_b,
                 a_alu_control, a_pc_src, a_illegal};
    assign vb = {b_state, b_pc_en, b_iord, b_mem_write, b_ir_write, b_reg_dst,
                 b_mem_to_reg, b_reg_write, b_alu_src_a, b_alu_src_b,
                 b_alu_control, b_pc_src, b_illegal};

    // Expected vectors per state (enable byte: pc_en iord mw irw rdst m2r rw srca).
    localparam logic [19:0] E_BOOT    = {4'd0,  8'b0000_0000, 2'b00, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_FETCH   = {4'd1,  8'b1001_0000, 2'b01, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_DECODE  = {4'd2,  8'b0000_0000, 2'b11, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_MEMADR  = {4'd3,  8'b0000_0001, 2'b10, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_MEMRD   = {4'd4,  8'b0100_0000, 2'b00, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_MEMWB   = {4'd5,  8'b0000_0110, 2'b00, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_MEMWR   = {4'd6,  8'b0110_0000, 2'b00, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_MULWAIT = {4'd8,  8'b0000_0001, 2'b00, 3'b101, 2'b00, 1'b0};
    localparam logic [19:0] E_ALUWB   = {4'd9,  8'b0000_1010, 2'b00, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_BR_T    = {4'd10, 8'b1000_0001, 2'b00, 3'b100, 2'b01, 1'b0};
    localparam logic [19:0] E_BR_NT   = {4'd10, 8'b0000_0001, 2'b00, 3'b100, 2'b01, 1'b0};
    localparam logic [19:0] E_ADDIEX  = {4'd11, 8'b0000_0001, 2'b10, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_ADDIWB  = {4'd12, 8'b0000_0010, 2'b00, 3'b010, 2'b00, 1'b0};
    localparam logic [19:0] E_JUMP    = {4'd13, 8'b1000_0000, 2'b00, 3'b010, 2'b10, 1'b0};
    localparam logic [19:0] E_TRAP    = {4'd14, 8'b0000_0000, 2'b00, 3'b010, 2'b00, 1'b1};

    function automatic logic [19:0] e_exec(input logic [2:0] alu);
        return {4'd7, 8'b0000_0001, 2'b00, alu, 2'b00, 1'b0};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over one edge, release 1 time unit after it: DUTs sit in BOOT.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total_cnt++;
        if (va !== E_BOOT) $display("FAIL reset_a_held: got %h want %h", va, E_BOOT);
        else pass_cnt++;
        total_cnt++;
        if (vb !== E_BOOT) $display("FAIL reset_b_held: got %h want %h", vb, E_BOOT);
        else pass_cnt++;
        do_reset();
        step();
        total_cnt++;
        if (va !== E_FETCH) $display("FAIL reset_to_fetch: got %h want %h", va, E_FETCH);
        else pass_cnt++;
    endtask

    // lw; opcode switched to sw while in MEMADR must be ignored.
    task automatic test_lw();
        logic [19:0] exp [7];
        exp = '{E_BOOT, E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        opcode = 6'b100011;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (va !== exp[i]) $display("FAIL lw[%0d]: got %h want %h", i, va, exp[i]);
            else pass_cnt++;
            if (i == 3) opcode = 6'b101011;
        end
    endtask

    task automatic test_sw_addi();
        logic [19:0] exp_sw [6];
        logic [19:0] exp_ad [6];
        exp_sw = '{E_BOOT, E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
        exp_ad = '{E_BOOT, E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH};
        opcode = 6'b101011;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (va !== exp_sw[i]) $display("FAIL sw[%0d]: got %h want %h", i, va, exp_sw[i]);
            else pass_cnt++;
        end
        opcode = 6'b001000;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (va !== exp_ad[i]) $display("FAIL addi[%0d]: got %h want %h", i, va, exp_ad[i]);
            else pass_cnt++;
        end
    endtask

    // Five R-type ops back to back without reset between them.
    task automatic test_back_to_back();
        logic [5:0]  fn [5];
        logic [2:0]  al [5];
        logic [19:0] exp [4];
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        al = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b110};
        opcode = 6'b000000;
        funct  = fn[0];
        do_reset();
        for (int k = 0; k < 5; k++) begin
            funct = fn[k];
            exp = '{E_FETCH, E_DECODE, e_exec(al[k]), E_ALUWB};
            for (int i = 0; i < 4; i++) begin
                step();
                total_cnt++;
                if (va !== exp[i])
                    $display("FAIL rtype[%0d][%0d]: got %h want %h", k, i, va, exp[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_mul();
        logic [19:0] exp_a [8];
        logic [19:0] exp_b [6];
        exp_a = '{E_BOOT, E_FETCH, E_DECODE, e_exec(3'b101), E_MULWAIT, E_MULWAIT,
                  E_ALUWB, E_FETCH};
        exp_b = '{E_BOOT, E_FETCH, E_DECODE, e_exec(3'b101), E_ALUWB, E_FETCH};
        opcode = 6'b000000;
        funct  = 6'b011100;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (va !== exp_a[i]) $display("FAIL mul3[%0d]: got %h want %h", i, va, exp_a[i]);
            else pass_cnt++;
            if (i < 6) begin
                total_cnt++;
                if (vb !== exp_b[i]) $display("FAIL mul1[%0d]: got %h want %h", i, vb, exp_b[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [19:0] exp [5];
        opcode = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero = (z == 1);
            exp = '{E_BOOT, E_FETCH, E_DECODE, (z == 1) ? E_BR_T : E_BR_NT, E_FETCH};
            do_reset();
            for (int i = 0; i < 5; i++) begin
                if (i > 0) step();
                total_cnt++;
                if (va !== exp[i])
                    $display("FAIL beq_z%0d[%0d]: got %h want %h", z, i, va, exp[i]);
                else pass_cnt++;
            end
        end
        zero   = 1'b0;
        opcode = 6'b000010;
        exp = '{E_BOOT, E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (va !== exp[i]) $display("FAIL jump[%0d]: got %h want %h", i, va, exp[i]);
            else pass_cnt++;
        end
    endtask

    // Illegal opcode then illegal funct: dut_a traps for good, dut_b drops it.
    task automatic test_illegal();
        logic [19:0] exp_a [6];
        logic [19:0] exp_b [6];
        exp_a = '{E_BOOT, E_FETCH, E_DECODE, E_TRAP, E_TRAP, E_TRAP};
        exp_b = '{E_BOOT, E_FETCH, E_DECODE, E_FETCH, E_DECODE, E_FETCH};
        opcode = 6'b111111;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (va !== exp_a[i]) $display("FAIL ill_op_a[%0d]: got %h want %h", i, va, exp_a[i]);
            else pass_cnt++;
            total_cnt++;
            if (vb !== exp_b[i]) $display("FAIL ill_op_b[%0d]: got %h want %h", i, vb, exp_b[i]);
            else pass_cnt++;
        end
        // A legal opcode presented while trapped changes nothing.
        opcode = 6'b100011;
        step();
        total_cnt++;
        if (va !== E_TRAP) $display("FAIL ill_sticky: got %h want %h", va, E_TRAP);
        else pass_cnt++;

        exp_a = '{E_BOOT, E_FETCH, E_DECODE, e_exec(3'b010), E_TRAP, E_TRAP};
        exp_b = '{E_BOOT, E_FETCH, E_DECODE, e_exec(3'b010), E_FETCH, E_DECODE};
        opcode = 6'b000000;
        funct  = 6'b000001;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (va !== exp_a[i]) $display("FAIL ill_fn_a[%0d]: got %h want %h", i, va, exp_a[i]);
            else pass_cnt++;
            total_cnt++;
            if (vb !== exp_b[i]) $display("FAIL ill_fn_b[%0d]: got %h want %h", i, vb, exp_b[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mulwait();
        logic [19:0] exp [8];
        opcode = 6'b000000;
        funct  = 6'b011100;
        do_reset();
        repeat (4) step();
        total_cnt++;
        if (va !== E_MULWAIT) $display("FAIL rmw_in_wait: got %h want %h", va, E_MULWAIT);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (va !== E_BOOT) $display("FAIL rmw_async: got %h want %h", va, E_BOOT);
        else pass_cnt++;
        step();
        total_cnt++;
        if (va !== E_BOOT) $display("FAIL rmw_held: got %h want %h", va, E_BOOT);
        else pass_cnt++;
        rst = 1'b0;
        exp = '{E_BOOT, E_FETCH, E_DECODE, e_exec(3'b101), E_MULWAIT, E_MULWAIT,
                E_ALUWB, E_FETCH};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            total_cnt++;
            if (va !== exp[i]) $display("FAIL rmw_again[%0d]: got %h want %h", i, va, exp[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b100000;
        zero   = 1'b0;
        test_reset();
        test_lw();
        test_sw_addi();
        test_back_to_back();
        test_mul();
        test_branch_jump();
        test_illegal();
        test_reset_mulwait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
